// File: rtl/layer_decoder_if.sv
// Bundle of the layer decoder's control, bitstream and result-handshake signals.
// master = the side that drives start/bit_in/out_ready; slave = the decoder.
interface layer_decoder_if #(
    parameter int NEURON_COUNT = 2,
    parameter int WINDOW_BITS  = 8
);
    logic                                        start;
    logic [NEURON_COUNT-1:0]                     bit_in;
    logic                                        busy;
    logic                                        out_valid;
    logic                                        out_ready;
    logic [NEURON_COUNT*(WINDOW_BITS+1)-1:0]     count_out;

    modport master (
        output start, bit_in, out_ready,
        input  busy, out_valid, count_out
    );

    modport slave (
        input  start, bit_in, out_ready,
        output busy, out_valid, count_out
    );
endinterface

// File: rtl/layer_decoder.sv
// Counts ones per stochastic lane over a 2^WINDOW_BITS cycle window and
// returns the per-lane counts through a valid/ready handshake.
module layer_decoder #(
    parameter int NEURON_COUNT = 2,
    parameter int WINDOW_BITS  = 8
) (
    input  logic           clk,
    input  logic           rst,
    layer_decoder_if.slave bus
);
    localparam int CW = WINDOW_BITS + 1;
    localparam logic [WINDOW_BITS-1:0] WIN_LAST = {WINDOW_BITS{1'b1}};
    localparam logic [WINDOW_BITS-1:0] WIN_ONE  = WINDOW_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                               state_r;
    state_t                               next_state_s;
    logic [WINDOW_BITS-1:0]               win_cnt_r;
    logic [NEURON_COUNT-1:0][CW-1:0]      lane_cnt_r;
    logic [NEURON_COUNT-1:0][CW-1:0]      lane_sum_s;
    logic [NEURON_COUNT*CW-1:0]           count_out_r;
    logic                                 busy_r;
    logic                                 out_valid_r;

    // Lane counters plus the current sample; used both for accumulation and
    // for the final load so the last sample of the window is never lost.
    always_comb begin
        lane_sum_s = {(NEURON_COUNT*CW){1'b0}};
        for (int i = 0; i < NEURON_COUNT; i++) begin
            lane_sum_s[i] = lane_cnt_r[i] + {{WINDOW_BITS{1'b0}}, bus.bit_in[i]};
        end
    end

    // Next-state logic: start only matters in IDLE, window end leaves ACCUM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state_s = ST_ACCUM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (win_cnt_r == WIN_LAST) begin
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_valid_r && bus.out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; status flags follow next state
    // so busy/out_valid are registered yet aligned with the state they report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            win_cnt_r   <= {WINDOW_BITS{1'b0}};
            lane_cnt_r  <= {(NEURON_COUNT*CW){1'b0}};
            count_out_r <= {(NEURON_COUNT*CW){1'b0}};
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= (next_state_s != ST_IDLE);
            out_valid_r <= (next_state_s == ST_HOLD);
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        win_cnt_r  <= {WINDOW_BITS{1'b0}};
                        lane_cnt_r <= {(NEURON_COUNT*CW){1'b0}};
                    end
                end
                ST_ACCUM: begin
                    lane_cnt_r <= lane_sum_s;
                    win_cnt_r  <= win_cnt_r + WIN_ONE;
                    if (win_cnt_r == WIN_LAST) begin
                        count_out_r <= lane_sum_s;
                    end
                end
                ST_HOLD: begin
                    count_out_r <= count_out_r;
                end
                default: begin
                    win_cnt_r <= {WINDOW_BITS{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.count_out = count_out_r;

endmodule
